btn_debounce: RTL

- Upstream input stage for all push-button consumers, including the traffic-signal top and its FSM.
- Each instance takes one raw, asynchronous, active-low board button and produces clean, synchronous, active-high events:
  - a debounced level
  - single-cycle press and release strobes
  - a single-cycle long-press strobe
- One instance per button. Outputs drive reset, traffic-request and future mode inputs directly.

---
 rtl/btn_debounce_pkg.sv | 14 +
 rtl/btn_debounce_sync_ff.sv | 23 ++
 rtl/btn_debounce.sv | 117 +++++++++++
 3 files changed

// File: rtl/btn_debounce_pkg.sv
// Shared types and constants for the push-button debouncer.
package btn_debounce_pkg;

  typedef enum logic [1:0] {
    BTN_IDLE         = 2'd0,
    BTN_PRESS_WAIT   = 2'd1,
    BTN_HELD         = 2'd2,
    BTN_RELEASE_WAIT = 2'd3
  } btn_state_t;

  // Idle level of an active-low button; also the synchronizer reset value.
  localparam logic BTN_RELEASED = 1'b1;

endpackage

// File: rtl/btn_debounce_sync_ff.sv
// Two-flop synchronizer for a single asynchronous input, with a selectable reset level.
module sync_ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic n_reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/btn_debounce.sv
// Debounces one raw active-low button into a registered level plus press,
// release and long-press strobes.
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter logic [31:0] DEBOUNCE_CNT = 32'd100000,
  parameter logic [31:0] LONG_CNT     = 32'd5000000
) (
  input  logic clk,
  input  logic n_reset,
  input  logic n_btn,
  output logic pressed,
  output logic press,
  output logic release_stb,  // "release" is a reserved word in SystemVerilog
  output logic long_press
);

  logic        sync_n;
  btn_state_t  state, state_d;
  logic [31:0] deb_cnt, deb_cnt_d;
  logic [31:0] hold_cnt, hold_cnt_d;
  logic        long_done, long_done_d;
  logic        pressed_d, press_d, release_d, long_d;

  sync_ff #(.RST_VAL(BTN_RELEASED)) u_sync (
    .clk     (clk),
    .n_reset (n_reset),
    .d       (n_btn),
    .q       (sync_n)
  );

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state       <= BTN_IDLE;
      deb_cnt     <= 32'd0;
      hold_cnt    <= 32'd0;
      long_done   <= 1'b0;
      pressed     <= 1'b0;
      press       <= 1'b0;
      release_stb <= 1'b0;
      long_press  <= 1'b0;
    end else begin
      state       <= state_d;
      deb_cnt     <= deb_cnt_d;
      hold_cnt    <= hold_cnt_d;
      long_done   <= long_done_d;
      pressed     <= pressed_d;
      press       <= press_d;
      release_stb <= release_d;
      long_press  <= long_d;
    end
  end

  always_comb begin
    state_d     = state;
    deb_cnt_d   = deb_cnt;
    hold_cnt_d  = hold_cnt;
    long_done_d = long_done;
    pressed_d   = pressed;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;

    case (state)
      BTN_IDLE: begin
        if (!sync_n) begin
          state_d   = BTN_PRESS_WAIT;
          deb_cnt_d = 32'd0;
        end
      end

      BTN_PRESS_WAIT: begin
        if (sync_n) begin
          state_d = BTN_IDLE;
        end else if (deb_cnt == DEBOUNCE_CNT - 32'd1) begin
          state_d     = BTN_HELD;
          pressed_d   = 1'b1;
          press_d     = 1'b1;
          hold_cnt_d  = 32'd0;
          long_done_d = 1'b0;
        end else begin
          deb_cnt_d = deb_cnt + 32'd1;
        end
      end

      // A release sample wins over a long-press that would fire this cycle.
      BTN_HELD: begin
        if (sync_n) begin
          state_d   = BTN_RELEASE_WAIT;
          deb_cnt_d = 32'd0;
        end else if (LONG_CNT != 32'd0 && !long_done) begin
          if (hold_cnt == LONG_CNT - 32'd1) begin
            long_d      = 1'b1;
            long_done_d = 1'b1;
          end else begin
            hold_cnt_d = hold_cnt + 32'd1;
          end
        end
      end

      BTN_RELEASE_WAIT: begin
        if (!sync_n) begin
          state_d = BTN_HELD;
        end else if (deb_cnt == DEBOUNCE_CNT - 32'd1) begin
          state_d   = BTN_IDLE;
          pressed_d = 1'b0;
          release_d = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt + 32'd1;
        end
      end

      default: state_d = BTN_IDLE;
    endcase
  end

endmodule
